divc_seq: RTL and testbench

Sequential restoring divider: the inverse companion to the shift-add multiplier unit (MultC), reusing its Start/Done control style. It holds its own controller and datapath and performs one shift-subtract step per clock. It produces an unsigned N-bit quotient and remainder, and flags division by zero. It sits beside the multiplier on the same Start/Done interface, so a single sequencer can drive either unit.

---
 rtl/divc_seq.sv | 115 +++++++++++
 tb/tb_divc_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/divc_seq.sv
// Sequential restoring divider: N-bit unsigned quotient/remainder, one shift-subtract step per clock.
// Latency N+1 cycles from accept to Done (1 for divide-by-zero); Start is only honoured in IDLE.
module divc_seq #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivByZero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [N:0]    a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    a_sh;
  logic [N:0]    t;
  logic          t_ok;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = (Divisor == '0) ? DONE : RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: shift {A,Q} left, trial-subtract B, keep the result only if non-negative.
  always_comb begin
    a_sh  = (N+1)'({a_q, q_q[N-1]});
    t     = a_sh - {1'b0, b_q};
    t_ok  = ~t[N];
    a_d   = a_q;
    q_d   = q_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d   = '0;
          q_d   = Dividend;
          b_d   = Divisor;
          cnt_d = CW'(N);
          dbz_d = (Divisor == '0);
          if (Divisor == '0) begin
            quo_d = '1;
            rem_d = Dividend;
          end
        end
      end
      RUN: begin
        a_d   = t_ok ? t : a_sh;
        q_d   = {q_q[N-2:0], t_ok};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d = q_d;
          rem_d = a_d[N-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    Busy = (state_q == RUN);
    Done = (state_q == DONE);
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_divc_seq.sv
// Bench for divc_seq: directed cases plus a held-Start random run against an a/b, a%b model.
module tb_divc_seq;
  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         Reset, Start;
  logic [N-1:0] Dividend, Divisor, Quotient, Remainder;
  logic         Busy, Done, DivByZero;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  divc_seq #(.N(N)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << N) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int ref_lat(input int b);
    return (b == 0) ? 0 : N;
  endfunction

  task automatic run_op(input int a, input int b);
    int done_at;
    int busy_cnt;
    @(negedge CLK);
    Start = 1'b1; Dividend = N'(a); Divisor = N'(b);
    @(posedge CLK);
    #1 Start = 1'b0;
    done_at = 0; busy_cnt = 0;
    for (int c = 1; c <= N + 4 && done_at == 0; c++) begin
      @(negedge CLK);
      if (Done === 1'b1) done_at = c;
      else if (Busy === 1'b1) busy_cnt++;
    end
    chk($sformatf("latency %0d/%0d", a, b), done_at, ref_lat(b) + 1);
    chk($sformatf("busy_cycles %0d/%0d", a, b), busy_cnt, ref_lat(b));
    chk($sformatf("busy_in_done %0d/%0d", a, b), Busy, 0);
    chk($sformatf("quot %0d/%0d", a, b), Quotient, ref_q(a, b));
    chk($sformatf("rem %0d/%0d", a, b), Remainder, ref_r(a, b));
    chk($sformatf("dbz %0d/%0d", a, b), DivByZero, (b == 0));
    @(negedge CLK);
    chk($sformatf("done_single %0d/%0d", a, b), Done, 0);
  endtask

  initial begin
    int done_cnt, done_at, cyc, last_done, ndone, ca, cb;
    bit drop_start;

    Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_quot", Quotient, 0);
    chk("rst_rem", Remainder, 0);
    chk("rst_dbz", DivByZero, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Reset = 1'b0;

    run_op(100, 7);
    run_op(255, 1);
    run_op(5, 9);
    run_op(255, 255);
    run_op(42, 0);
    run_op(10, 3);

    // Inputs wiggle without Start: results must hold.
    Dividend = 8'd77; Divisor = 8'd0;
    repeat (3) @(negedge CLK);
    chk("hold_quot", Quotient, 3);
    chk("hold_rem", Remainder, 1);
    chk("hold_dbz", DivByZero, 0);
    chk("hold_busy", Busy, 0);

    // Reset sampled 4 edges after accept aborts the operation.
    @(negedge CLK);
    Start = 1'b1; Dividend = 8'd200; Divisor = 8'd3;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_quot", Quotient, 0);
    chk("abort_rem", Remainder, 0);
    chk("abort_dbz", DivByZero, 0);
    Reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge CLK);
      if (Done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    run_op(200, 3);

    // Start pulses during RUN and during DONE must be ignored.
    @(negedge CLK);
    Start = 1'b1; Dividend = 8'd50; Divisor = 8'd5;
    @(posedge CLK);
    #1 Start = 1'b0;
    done_cnt = 0; done_at = 0; drop_start = 1'b0;
    for (int c = 1; c <= 2 * N + 6; c++) begin
      @(negedge CLK);
      if (drop_start) begin
        Start = 1'b0; drop_start = 1'b0;
      end
      if (c == 3) begin
        Start = 1'b1; Dividend = 8'd9; Divisor = 8'd2;
      end
      if (c == 4) Start = 1'b0;
      if (Done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
        chk("ign_quot", Quotient, 10);
        chk("ign_rem", Remainder, 0);
        Start = 1'b1; drop_start = 1'b1;
      end
    end
    chk("ign_done_count", done_cnt, 1);
    chk("ign_latency", done_at, N + 1);

    // Held Start: Done-to-Done spacing is the new op's latency plus 2.
    @(negedge CLK);
    cyc = 0; last_done = -1; ndone = 0;
    ca = $urandom_range(0, 255); cb = $urandom_range(1, 255);
    Dividend = N'(ca); Divisor = N'(cb); Start = 1'b1;
    while (ndone < 1000 && cyc < 15000) begin
      @(negedge CLK);
      cyc++;
      if (Done === 1'b1) begin
        chk("b2b_gap", cyc - last_done, ref_lat(cb) + 2);
        chk($sformatf("b2b_quot %0d/%0d", ca, cb), Quotient, ref_q(ca, cb));
        chk($sformatf("b2b_rem %0d/%0d", ca, cb), Remainder, ref_r(ca, cb));
        chk("b2b_dbz", DivByZero, (cb == 0));
        last_done = cyc;
        ndone++;
        ca = $urandom_range(0, 255);
        cb = (ndone % 97 == 0) ? 0 : $urandom_range(0, 255);
        Dividend = N'(ca); Divisor = N'(cb);
        if (ndone == 1000) Start = 1'b0;
      end
    end
    chk("b2b_completed", ndone, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
